piece_bag_generator: RTL and testbench
======================================

Name: piece_bag_generator

Overview:
- Parametrised successor to the XOR-combined LFSR bank, used as the Tetris piece source.
- A bank of Galois LFSRs is XOR-combined into one random word. A "bag" randomiser draws from it by rejection sampling, so every run of piece_num_p accepted pieces is a permutation of 0..piece_num_p-1.
- Accepted pieces are buffered in a preview FIFO. The head is delivered over valid/ready to the game FSM; the following entries are exposed for the "next piece" display.

Parameters:
- width_p, 32, LFSR state width.
- lfsr_num_p, 4, number of LFSRs in the bank (>=1).
- taps_p, {lfsr_num_p{32'h8020_0003}}, per-LFSR Galois tap mask, [lfsr_num_p-1:0][width_p-1:0].
- piece_num_p, 7, number of distinct pieces (2..2**width_p).
- preview_p, 3, preview entries exposed. FIFO depth is preview_p+1.
- Localparam piece_w = $clog2(piece_num_p).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- reseed_i  in  1  one-cycle pulse: load new seed, flush bag and FIFO.
- seed_i  in  width_p  seed applied with reseed_i.
- piece_o  out  piece_w  FIFO head piece index.
- valid_o  out  1  piece_o is valid.
- ready_i  in  1  consumer takes piece_o when valid_o && ready_i.
- preview_o  out  preview_p*piece_w  entry k = k-th piece after the head; slice 0 = LSBs.
- preview_valid_o  out  preview_p  bit k set when preview entry k is occupied.

Behaviour:
- LFSR i: default seed D_i = i*i + 2*i + 4.
  - Steps every cycle, including cycles with reset_i and reseed_i deasserted: if state[0], state <= (state>>1) ^ taps_p[i]; else state <= state>>1.
- Random word r = XOR of all LFSR states, combinational from registered state.
- Reset: LFSR i <= D_i; bag mask <= all ones; FIFO empty. valid_o=0, preview_valid_o=0, piece_o=0, preview_o=0.
- reseed_i (reset_i has priority over it): LFSR i <= seed_i ^ D_i, or D_i if that result is zero. Bag mask <= all ones; FIFO flushed. Any pop in that cycle is discarded.
- Draw, every cycle in which the FIFO is not full (count < preview_p+1) and neither reset_i nor reseed_i is asserted:
  - c = r[piece_w-1:0].
  - Accept iff c < piece_num_p and mask[c]=1.
  - On accept: push c, clear mask[c]. If the mask becomes all zero, reload all ones in the same cycle.
  - On reject: nothing happens; retry next cycle with the new r.
- Full FIFO: no draw, mask unchanged, LFSRs still step.
- Push and pop in the same cycle are legal whenever push is legal; count is unchanged.
- A pop on a full FIFO frees a slot only from the next cycle.
- Pieces are visible one cycle after acceptance, because the FIFO is registered. valid_o rises at least 1 cycle after reset deasserts.
- While valid_o && !ready_i, piece_o and preview_o are held stable.
- Unoccupied preview slots drive 0.
- Invariants:
  - A piece index never appears twice among the accepted pieces of one bag epoch.
  - An epoch ends on mask reload, reset or reseed.
  - No output ever has piece index >= piece_num_p.

Decomposition:
- Package tetris_rng_pkg holds:
  - the default tap constant 32'h8020_0003;
  - function default_seed(i) = i*i + 2*i + 4;
  - the piece_w computation;
  - the piece-index typedef for piece_num_p=7.
- Sub-module lfsr_galois implements a single LFSR. Params: width_p, taps_p, seed_p. Ports: clk_i, reset_i, reseed_i, seed_i, state_o. It is instantiated lfsr_num_p times in a generate loop.
- Bag mask, draw logic and the preview FIFO are kept inline.

Test Plan:
- Reset, ready_i=1 for 700 accepted pieces:
  - each consecutive group of 7 is a permutation of 0..6 (100 bags);
  - no value >= 7;
  - valid_o=0 during reset and in the cycle after.
- ready_i=0 after reset until valid_o && preview_valid_o=3'b111:
  - count stops at 4;
  - piece_o and preview_o stable for 50 cycles;
  - raising ready_i pops the head, and preview entry 0 appears on piece_o next cycle.
- Reseed with seed 32'hDEAD_BEEF at two different times, after arbitrary traffic:
  - the 28 pieces following each reseed are identical sequences;
  - valid_o=0 in the cycle after reseed_i.
- seed_i = 32'h0000_0004 (LFSR 0 result zero → falls back to D_0):
  - no lock-up;
  - pieces keep arriving, valid_o asserted within 64 cycles.
- reset_i asserted mid-bag after 3 pieces, with reseed_i also high in that cycle:
  - reset wins; outputs return to reset values;
  - the next 7 pieces form a full permutation;
  - the sequence equals the one from the first scenario.
- piece_num_p=5, preview_p=1, lfsr_num_p=2 build:
  - 500 pieces are in valid permutation groups of 5;
  - candidates 5..7 are never output.

Source files
------------

// File: rtl/tetris_rng_pkg.sv
// Shared constants and helpers for the Tetris piece randomiser.
// Contents:
//   default_taps  - Galois tap mask used by every LFSR unless overridden
//   default_seed  - reset seed of LFSR i: i*i + 2*i + 4
//   piece_width   - bits needed to hold a piece index 0..n-1
//   piece_t       - piece index type for the standard 7-piece set
package tetris_rng_pkg;

    localparam logic [31:0] default_taps = 32'h8020_0003;

    function automatic logic [31:0] default_seed(input int unsigned i);
        return 32'(i * i + 2 * i + 4);
    endfunction

    function automatic int unsigned piece_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned std_piece_num = 7;
    localparam int unsigned std_piece_w   = piece_width(std_piece_num);

    typedef logic [std_piece_w-1:0] piece_t;

endpackage

// File: rtl/lfsr_galois.sv
// Single Galois LFSR, shifting right one step per clock.
// Ports:
//   clk_i    - clock
//   reset_i  - synchronous active-high reset, loads seed_p
//   reseed_i - loads seed_i ^ seed_p (seed_p if that would be zero)
//   seed_i   - external seed
//   state_o  - current register state
module lfsr_galois #(
    parameter int unsigned        width_p = 32,
    parameter logic [width_p-1:0] taps_p  = width_p'(32'h8020_0003),
    parameter logic [width_p-1:0] seed_p  = width_p'(4)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               reseed_i,
    input  logic [width_p-1:0] seed_i,
    output logic [width_p-1:0] state_o
);

    logic [width_p-1:0] mixed;

    assign mixed = seed_i ^ seed_p;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_o <= seed_p;
        end else if (reseed_i) begin
            // an all-zero state would lock the register forever
            state_o <= (mixed == '0) ? seed_p : mixed;
        end else if (state_o[0]) begin
            state_o <= (state_o >> 1) ^ taps_p;
        end else begin
            state_o <= state_o >> 1;
        end
    end

endmodule

// File: rtl/piece_bag_generator.sv
// Tetris piece source: XOR-combined LFSR bank feeding a bag randomiser
// (rejection sampling without replacement) and a registered preview FIFO.
// Ports:
//   clk_i           - clock
//   reset_i         - synchronous active-high reset
//   reseed_i        - pulse: reload LFSRs from seed_i, flush bag and FIFO
//   seed_i          - seed applied with reseed_i
//   piece_o         - FIFO head piece index (0 when empty)
//   valid_o         - piece_o holds a piece
//   ready_i         - consumer takes piece_o when valid_o && ready_i
//   preview_o       - entry k = k-th piece after the head, slice 0 in LSBs
//   preview_valid_o - bit k set when preview entry k is occupied
module piece_bag_generator
    import tetris_rng_pkg::*;
#(
    parameter int unsigned                        width_p     = 32,
    parameter int unsigned                        lfsr_num_p  = 4,
    parameter logic [lfsr_num_p-1:0][width_p-1:0] taps_p      = {lfsr_num_p{default_taps}},
    parameter int unsigned                        piece_num_p = 7,
    parameter int unsigned                        preview_p   = 3,
    localparam int unsigned                       piece_w     = piece_width(piece_num_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           reseed_i,
    input  logic [width_p-1:0]             seed_i,
    output logic [piece_w-1:0]             piece_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [preview_p*piece_w-1:0]   preview_o,
    output logic [preview_p-1:0]           preview_valid_o
);

    localparam int unsigned depth   = preview_p + 1;
    localparam int unsigned count_w = $clog2(depth + 1);

    typedef logic [piece_w-1:0] idx_t;

    logic [lfsr_num_p-1:0][width_p-1:0] lfsr_state;
    logic [width_p-1:0]                 rand_word;
    logic [width_p-1:0]                 unused_rand_word;

    logic [piece_num_p-1:0] mask, mask_next;
    idx_t                   entries [depth];
    idx_t                   entries_next [depth];
    logic [count_w-1:0]     count, count_next, wr_idx;

    idx_t cand;
    logic cand_ok, accept, pop, full;

    for (genvar i = 0; i < lfsr_num_p; i++) begin : g_lfsr
        localparam logic [width_p-1:0] seed_c = width_p'(default_seed(i));

        lfsr_galois #(
            .width_p (width_p),
            .taps_p  (taps_p[i]),
            .seed_p  (seed_c)
        ) u_lfsr (
            .clk_i    (clk_i),
            .reset_i  (reset_i),
            .reseed_i (reseed_i),
            .seed_i   (seed_i),
            .state_o  (lfsr_state[i])
        );
    end

    always_comb begin
        rand_word = '0;
        for (int unsigned i = 0; i < lfsr_num_p; i++) begin
            rand_word = rand_word ^ lfsr_state[i];
        end
    end

    // only the low piece_w bits feed the draw
    assign unused_rand_word = rand_word;
    assign cand             = rand_word[piece_w-1:0];

    assign full = (count == count_w'(depth));
    assign pop  = (count != '0) && ready_i;

    always_comb begin
        cand_ok = 1'b0;
        if (32'(cand) < piece_num_p) begin
            cand_ok = mask[cand];
        end
        accept = cand_ok && !full;

        mask_next = mask;
        if (accept) begin
            mask_next[cand] = 1'b0;
            if (mask_next == '0) begin
                mask_next = '1;
            end
        end

        // shift-register FIFO: entry 0 is the head, vacated slots read as 0
        entries_next = entries;
        if (pop) begin
            for (int unsigned k = 0; k < depth - 1; k++) begin
                entries_next[k] = entries[k+1];
            end
            entries_next[depth-1] = '0;
        end

        wr_idx = pop ? count - 1'b1 : count;
        for (int unsigned k = 0; k < depth; k++) begin
            if (accept && (wr_idx == count_w'(k))) begin
                entries_next[k] = cand;
            end
        end

        count_next = count + count_w'(accept) - count_w'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || reseed_i) begin
            mask  <= '1;
            count <= '0;
            for (int unsigned k = 0; k < depth; k++) begin
                entries[k] <= '0;
            end
        end else begin
            mask    <= mask_next;
            count   <= count_next;
            entries <= entries_next;
        end
    end

    assign valid_o = (count != '0);
    assign piece_o = entries[0];

    for (genvar k = 0; k < preview_p; k++) begin : g_preview
        assign preview_o[k*piece_w +: piece_w] = entries[k+1];
        assign preview_valid_o[k]              = (count > count_w'(k + 1));
    end

endmodule

// File: tb/tb_piece_bag_generator.sv
module tb_piece_bag_generator;
    import tetris_rng_pkg::*;

    localparam int unsigned NL    = 4;
    localparam int unsigned NP    = 7;
    localparam int unsigned PV    = 3;
    localparam int unsigned DEPTH = PV + 1;
    localparam logic [31:0] TAP   = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        reseed_i = 1'b0;
    logic        ready_i = 1'b1;
    logic [31:0] seed_i = '0;
    piece_t      piece_o;
    logic        valid_o;
    logic [8:0]  preview_o;
    logic [2:0]  preview_valid_o;

    logic        ready5 = 1'b1;
    logic [2:0]  piece5;
    logic        valid5;
    logic [2:0]  preview5;
    logic        pv5;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    piece_bag_generator #(
        .width_p     (32),
        .lfsr_num_p  (NL),
        .taps_p      ({4{TAP}}),
        .piece_num_p (NP),
        .preview_p   (PV)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .reseed_i        (reseed_i),
        .seed_i          (seed_i),
        .piece_o         (piece_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .preview_o       (preview_o),
        .preview_valid_o (preview_valid_o)
    );

    piece_bag_generator #(
        .width_p     (32),
        .lfsr_num_p  (2),
        .taps_p      ({2{TAP}}),
        .piece_num_p (5),
        .preview_p   (1)
    ) dut5 (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .reseed_i        (1'b0),
        .seed_i          (32'h0),
        .piece_o         (piece5),
        .valid_o         (valid5),
        .ready_i         (ready5),
        .preview_o       (preview5),
        .preview_valid_o (pv5)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (default build) ----------------
    logic [31:0]   ml [NL];
    logic [NP-1:0] mmask;
    int            mfifo[$];
    int            exp_q[$];

    function automatic logic [31:0] ref_seed(input int i);
        return 32'(4 + i * (i + 2));
    endfunction

    always @(posedge clk) begin
        logic [31:0] r;
        logic [31:0] s;
        int          c;
        bit          acc;
        if (reset_i) begin
            for (int i = 0; i < NL; i++) ml[i] = ref_seed(i);
            mmask = '1;
            mfifo.delete();
            exp_q.delete();
        end else if (reseed_i) begin
            for (int i = 0; i < NL; i++) begin
                s = seed_i ^ ref_seed(i);
                ml[i] = (s == 0) ? ref_seed(i) : s;
            end
            mmask = '1;
            mfifo.delete();
            exp_q.delete();
        end else begin
            r = '0;
            for (int i = 0; i < NL; i++) r = r ^ ml[i];
            c = int'(r[2:0]);
            acc = 1'b0;
            if (mfifo.size() < DEPTH && c < NP) acc = mmask[c];
            if (mfifo.size() > 0 && ready_i) void'(mfifo.pop_front());
            if (acc) begin
                mfifo.push_back(c);
                exp_q.push_back(c);
                mmask[c] = 1'b0;
                if (mmask == '0) mmask = '1;
            end
            for (int i = 0; i < NL; i++)
                ml[i] = ml[i][0] ? ((ml[i] >> 1) ^ TAP) : (ml[i] >> 1);
        end
    end

    // ---------------- monitor / scoreboard (default build) ----------------
    logic [NP-1:0] seen = '0;
    int            seen_n = 0;
    int            bags = 0;
    int            got[$];

    always @(negedge clk) begin
        int         n;
        int         e;
        logic [2:0] exp_pv;
        logic [8:0] exp_prev;
        logic [2:0] exp_head;
        n = mfifo.size();
        exp_pv = '0;
        exp_prev = '0;
        exp_head = '0;
        if (n > 0) exp_head = 3'(mfifo[0]);
        for (int k = 0; k < PV; k++) begin
            if (n > k + 1) begin
                exp_pv[k] = 1'b1;
                exp_prev[k*3 +: 3] = 3'(mfifo[k+1]);
            end
        end
        chk("valid_o", valid_o, n > 0);
        chk("head", piece_o, exp_head);
        chk("preview_valid", preview_valid_o, exp_pv);
        chk("preview", preview_o, exp_prev);

        if (reset_i || reseed_i) begin
            seen = '0;
            seen_n = 0;
        end else if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", valid_o, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_piece", piece_o, e);
            end
            got.push_back(int'(piece_o));
            chk("range", piece_o < NP, 1);
            if (piece_o < NP) begin
                chk("bag_dup", seen[piece_o], 0);
                seen[piece_o] = 1'b1;
                seen_n++;
                if (seen_n == NP) begin
                    seen = '0;
                    seen_n = 0;
                    bags++;
                end
            end
        end
    end

    // ---------------- 5-piece build: property checks ----------------
    logic [4:0] seen5 = '0;
    int         n5 = 0;
    int         bags5 = 0;

    always @(negedge clk) begin
        if (reset_i) begin
            seen5 = '0;
            n5 = 0;
            bags5 = 0;
        end else begin
            chk("p5_preview_idle", pv5 ? 3'd0 : preview5, 0);
            if (valid5 && ready5) begin
                chk("p5_range", piece5 < 5, 1);
                if (piece5 < 5) begin
                    chk("p5_bag_dup", seen5[piece5], 0);
                    seen5[piece5] = 1'b1;
                    n5++;
                    if (n5 == 5) begin
                        seen5 = '0;
                        n5 = 0;
                        bags5++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ready5 = 1'($urandom_range(0, 4) != 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_got(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (got.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(name, got.size() >= n, 1);
    endtask

    task automatic reseed_with(input logic [31:0] s);
        seed_i = s;
        reseed_i = 1'b1;
        ready_i = 1'b1;
        tick();
        reseed_i = 1'b0;
        chk("valid_after_reseed", valid_o, 0);
        got.delete();
    endtask

    int         seq_a [7];
    int         seq_r [28];
    int         k;
    logic [2:0] hold_piece;
    logic [8:0] hold_prev;

    initial begin
        // 1: reset, free-running consumer
        reset_i = 1'b1;
        ready_i = 1'b1;
        repeat (3) begin
            tick();
            chk("reset_valid", valid_o, 0);
            chk("reset_piece", piece_o, 0);
            chk("reset_preview", preview_o, 0);
            chk("reset_pvalid", preview_valid_o, 0);
        end
        reset_i = 1'b0;
        got.delete();
        bags = 0;
        chk("valid_cycle_after_reset", valid_o, 0);
        tick();
        chk("first_valid", valid_o, 1);
        chk("first_piece", piece_o, 4);
        wait_got(700, 20000, "s1_700_pieces");
        chk("s1_bags", bags, 100);
        chk("hand_piece0", got[0], 4);
        chk("hand_piece1", got[1], 6);
        chk("hand_piece2", got[2], 0);
        for (int i = 0; i < 7; i++) seq_a[i] = got[i];

        // 2: stalled consumer fills the FIFO
        reset_i = 1'b1;
        ready_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;
        k = 0;
        while (!(valid_o && preview_valid_o == 3'b111) && k < 200) begin
            tick();
            k++;
        end
        chk("s2_fill", {valid_o, preview_valid_o}, 4'hF);
        hold_piece = piece_o;
        hold_prev = preview_o;
        repeat (50) begin
            tick();
            chk("s2_hold_piece", piece_o, hold_piece);
            chk("s2_hold_preview", preview_o, hold_prev);
            chk("s2_hold_count", {valid_o, preview_valid_o}, 4'hF);
        end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("s2_advance_head", piece_o, hold_prev[2:0]);
        chk("s2_advance_preview", preview_o[5:0], hold_prev[8:3]);
        chk("s2_no_push_on_full_pop", preview_valid_o, 3'b011);

        // 3: reseed repeatability
        repeat (37) begin
            ready_i = 1'($urandom_range(0, 1));
            tick();
        end
        reseed_with(32'hDEAD_BEEF);
        wait_got(28, 2000, "s3_first_28");
        for (int i = 0; i < 28; i++) seq_r[i] = got[i];
        repeat (53) begin
            ready_i = 1'($urandom_range(0, 1));
            tick();
        end
        reseed_with(32'hDEAD_BEEF);
        wait_got(28, 2000, "s3_second_28");
        for (int i = 0; i < 28; i++) chk("s3_repeat", got[i], seq_r[i]);

        // 4: seed that zeroes LFSR 0
        reseed_with(32'h0000_0004);
        k = 0;
        while (!valid_o && k < 64) begin
            tick();
            k++;
        end
        chk("s4_valid_within_64", valid_o, 1);
        wait_got(21, 2000, "s4_flow");

        // 5: reset and reseed together mid-bag
        reset_i = 1'b1;
        ready_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        got.delete();
        k = 0;
        while (got.size() < 3 && k < 200) begin
            tick();
            k++;
        end
        chk("s5_three_pieces", got.size() >= 3, 1);
        reset_i = 1'b1;
        reseed_i = 1'b1;
        seed_i = 32'hDEAD_BEEF;
        tick();
        reseed_i = 1'b0;
        chk("s5_reset_valid", valid_o, 0);
        chk("s5_reset_piece", piece_o, 0);
        chk("s5_reset_preview", preview_o, 0);
        chk("s5_reset_pvalid", preview_valid_o, 0);
        tick();
        reset_i = 1'b0;
        got.delete();
        wait_got(7, 500, "s5_seven");
        for (int i = 0; i < 7; i++) chk("s5_same_as_s1", got[i], seq_a[i]);

        // 6: 5-piece build, 100 complete bags since the last reset
        k = 0;
        while (bags5 < 100 && k < 20000) begin
            tick();
            k++;
        end
        chk("p5_bags", bags5 >= 100, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
